// File: rtl/reg_writeback_unit.sv
// Register-file write-port controller: merges ALU and load results into one
// registered write port, keeps a busy scoreboard and forwards the in-flight write.
module reg_writeback_unit #(
  parameter int DATA_WIDTH_P = 32,
  parameter int ADDR_WIDTH_P = 5,
  parameter int DEPTH_P      = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_issue_valid,
  input  logic [ADDR_WIDTH_P-1:0] i_issue_rd,
  input  logic                    i_alu_valid,
  input  logic [ADDR_WIDTH_P-1:0] i_alu_rd,
  input  logic [DATA_WIDTH_P-1:0] i_alu_data,
  input  logic                    i_ld_valid,
  output logic                    o_ld_ready,
  input  logic [ADDR_WIDTH_P-1:0] i_ld_rd,
  input  logic [DATA_WIDTH_P-1:0] i_ld_data,
  output logic                    o_wr_enable,
  output logic [ADDR_WIDTH_P-1:0] o_wr_addr,
  output logic [DATA_WIDTH_P-1:0] o_wr_data,
  input  logic [ADDR_WIDTH_P-1:0] i_chk_addr_a,
  input  logic [ADDR_WIDTH_P-1:0] i_chk_addr_b,
  output logic                    o_busy_a,
  output logic                    o_busy_b,
  output logic                    o_fwd_valid_a,
  output logic [DATA_WIDTH_P-1:0] o_fwd_data_a,
  output logic                    o_fwd_valid_b,
  output logic [DATA_WIDTH_P-1:0] o_fwd_data_b,
  output logic                    o_waw_err
);

  logic                    hold_valid;
  logic [ADDR_WIDTH_P-1:0] hold_rd;
  logic [DATA_WIDTH_P-1:0] hold_data;
  logic [DEPTH_P-1:0]      busy;
  logic [DEPTH_P-1:0]      busy_next;

  logic                    ld_fire;
  logic                    ld_capture;
  logic                    hold_drain;
  logic                    issue_set;
  logic                    sel_en;
  logic [ADDR_WIDTH_P-1:0] sel_rd;
  logic [DATA_WIDTH_P-1:0] sel_data;

  assign o_ld_ready = !hold_valid;
  assign ld_fire    = i_ld_valid && !hold_valid;
  assign issue_set  = i_issue_valid && (i_issue_rd != '0);
  // A load beaten by the ALU parks in the buffer; x0 loads are simply dropped.
  assign ld_capture = ld_fire && i_alu_valid && (i_ld_rd != '0);

  // Write-stage source selection: ALU > held load > direct load.
  always_comb begin
    sel_en     = 1'b0;
    sel_rd     = hold_rd;
    sel_data   = hold_data;
    hold_drain = 1'b0;
    if (i_alu_valid) begin
      sel_en   = (i_alu_rd != '0);
      sel_rd   = i_alu_rd;
      sel_data = i_alu_data;
    end else if (hold_valid) begin
      sel_en     = 1'b1;
      hold_drain = 1'b1;
    end else if (ld_fire) begin
      sel_en   = (i_ld_rd != '0);
      sel_rd   = i_ld_rd;
      sel_data = i_ld_data;
    end
  end

  // Issue set is applied after the writeback clear so it wins on a collision.
  always_comb begin
    busy_next = busy;
    if (sel_en)    busy_next[sel_rd]     = 1'b0;
    if (issue_set) busy_next[i_issue_rd] = 1'b1;
  end

  // ---- W stage and control state ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_wr_enable <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      hold_valid  <= 1'b0;
      busy        <= '0;
      o_waw_err   <= 1'b0;
    end else begin
      o_wr_enable <= sel_en;
      if (sel_en) begin
        o_wr_addr <= sel_rd;
        o_wr_data <= sel_data;
      end
      if (ld_capture)      hold_valid <= 1'b1;
      else if (hold_drain) hold_valid <= 1'b0;
      busy <= busy_next;
      if (issue_set && busy[i_issue_rd]) o_waw_err <= 1'b1;
    end
  end

  // Buffer payload is qualified by hold_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (ld_capture) begin
      hold_rd   <= i_ld_rd;
      hold_data <= i_ld_data;
    end
  end

  // ---- hazard and forwarding ----
  assign o_fwd_valid_a = o_wr_enable && (o_wr_addr == i_chk_addr_a) && (i_chk_addr_a != '0);
  assign o_fwd_valid_b = o_wr_enable && (o_wr_addr == i_chk_addr_b) && (i_chk_addr_b != '0);
  assign o_fwd_data_a  = o_wr_data;
  assign o_fwd_data_b  = o_wr_data;
  assign o_busy_a      = busy[i_chk_addr_a] && !o_fwd_valid_a;
  assign o_busy_b      = busy[i_chk_addr_b] && !o_fwd_valid_b;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Scoreboard bench for reg_writeback_unit: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_reg_writeback_unit;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_issue_valid, i_alu_valid, i_ld_valid;
  logic [AW-1:0] i_issue_rd, i_alu_rd, i_ld_rd, i_chk_addr_a, i_chk_addr_b;
  logic [DW-1:0] i_alu_data, i_ld_data;
  logic          o_ld_ready, o_wr_enable, o_busy_a, o_busy_b;
  logic          o_fwd_valid_a, o_fwd_valid_b, o_waw_err;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data, o_fwd_data_a, o_fwd_data_b;

  always #5 clk = ~clk;

  reg_writeback_unit #(.DATA_WIDTH_P(DW), .ADDR_WIDTH_P(AW), .DEPTH_P(NR)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
    .o_wr_enable(o_wr_enable), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .i_chk_addr_a(i_chk_addr_a), .i_chk_addr_b(i_chk_addr_b),
    .o_busy_a(o_busy_a), .o_busy_b(o_busy_b),
    .o_fwd_valid_a(o_fwd_valid_a), .o_fwd_data_a(o_fwd_data_a),
    .o_fwd_valid_b(o_fwd_valid_b), .o_fwd_data_b(o_fwd_data_b),
    .o_waw_err(o_waw_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [AW-1:0] rd; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } res_t;

  // Reference model: pending expected writes, parked loads, busy set, current W.
  wr_t           exp_q[$];
  res_t          hold_q[$];
  bit            m_busy[NR];
  bit            m_err;
  bit            m_w_en;
  logic [AW-1:0] m_w_rd;
  logic [DW-1:0] m_w_d;

  bit            exp_valid = 1'b0;
  bit            e_ready, e_fwd_a, e_fwd_b, e_busy_a, e_busy_b, e_err;
  logic [DW-1:0] e_fwd_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    hold_q.delete();
    exp_q.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_err  = 1'b0;
    m_w_en = 1'b0;
    m_w_rd = '0;
    m_w_d  = '0;
  endtask

  // One clock of stimulus; records what the outputs must show this cycle and
  // advances the model to the state after the next edge.
  task automatic cycle(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldd,
                       input bit iv, input logic [AW-1:0] ird,
                       input logic [AW-1:0] ca, input logic [AW-1:0] cb, output bit acc);
    bit            nw_en;
    logic [AW-1:0] nw_rd;
    logic [DW-1:0] nw_d;
    res_t          r;
    @(posedge clk); #1;
    i_alu_valid = av;  i_alu_rd = ard;  i_alu_data = ad;
    i_ld_valid  = lv;  i_ld_rd  = lrd;  i_ld_data  = ldd;
    i_issue_valid = iv; i_issue_rd = ird;
    i_chk_addr_a = ca;  i_chk_addr_b = cb;

    e_ready  = (hold_q.size() == 0);
    e_fwd_a  = m_w_en && (m_w_rd == ca) && (ca != 0);
    e_fwd_b  = m_w_en && (m_w_rd == cb) && (cb != 0);
    e_fwd_d  = m_w_d;
    e_busy_a = m_busy[ca] && !e_fwd_a;
    e_busy_b = m_busy[cb] && !e_fwd_b;
    e_err    = m_err;
    exp_valid = 1'b1;

    acc   = lv && e_ready;
    nw_en = 1'b0;
    nw_rd = '0;
    nw_d  = '0;
    if (av) begin
      if (ard != 0) begin nw_en = 1'b1; nw_rd = ard; nw_d = ad; end
      if (acc && lrd != 0) begin r.rd = lrd; r.data = ldd; hold_q.push_back(r); end
    end else if (hold_q.size() > 0) begin
      r = hold_q.pop_front();
      nw_en = 1'b1; nw_rd = r.rd; nw_d = r.data;
    end else if (acc && lrd != 0) begin
      nw_en = 1'b1; nw_rd = lrd; nw_d = ldd;
    end

    if (iv && ird != 0 && m_busy[ird]) m_err = 1'b1;
    if (nw_en) begin
      m_busy[nw_rd] = 1'b0;
      exp_q.push_back('{cyc + 1, nw_rd, nw_d});
      m_w_rd = nw_rd;
      m_w_d  = nw_d;
    end
    m_w_en = nw_en;
    if (iv && ird != 0) m_busy[ird] = 1'b1;
  endtask

  task automatic idle(input logic [AW-1:0] ca, input logic [AW-1:0] cb);
    bit acc;
    cycle(0, '0, '0, 0, '0, '0, 0, '0, ca, cb, acc);
  endtask

  // Monitor: pops the scoreboard whenever a write is due and checks hazard outputs.
  always @(negedge clk) begin
    wr_t w;
    if (exp_valid && reset_n) begin
      chk("ld_ready", o_ld_ready, e_ready);
      chk("fwd_valid_a", o_fwd_valid_a, e_fwd_a);
      chk("fwd_valid_b", o_fwd_valid_b, e_fwd_b);
      chk("busy_a", o_busy_a, e_busy_a);
      chk("busy_b", o_busy_b, e_busy_b);
      chk("waw_err", o_waw_err, e_err);
      if (e_fwd_a) chk("fwd_data_a", o_fwd_data_a, e_fwd_d);
      if (e_fwd_b) chk("fwd_data_b", o_fwd_data_b, e_fwd_d);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        w = exp_q.pop_front();
        chk("wr_enable", o_wr_enable, 1);
        chk("wr_addr", o_wr_addr, w.rd);
        chk("wr_data", o_wr_data, w.data);
      end else begin
        chk("wr_enable_idle", o_wr_enable, 0);
      end
    end
  end

  // Asynchronous reset pulse in the middle of the current cycle.
  task automatic async_reset(input logic [AW-1:0] ca);
    #2;
    reset_n   = 1'b0;
    exp_valid = 1'b0;
    model_clear();
    #1;
    chk("rst_wr_enable", o_wr_enable, 0);
    chk("rst_ld_ready", o_ld_ready, 1);
    chk("rst_busy_a", o_busy_a, 0);
    chk("rst_fwd_a", o_fwd_valid_a, 0);
    chk("rst_waw_err", o_waw_err, 0);
    chk("rst_chk_addr", i_chk_addr_a, ca);
    i_alu_valid = 0; i_ld_valid = 0; i_issue_valid = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bit            acc, lp, av, iv;
    logic [AW-1:0] lrd, ard, ird, ca, cb;
    logic [DW-1:0] ldd, ad;

    reset_n = 1'b0;
    i_issue_valid = 0; i_issue_rd = '0; i_alu_valid = 0; i_alu_rd = '0; i_alu_data = '0;
    i_ld_valid = 0; i_ld_rd = '0; i_ld_data = '0; i_chk_addr_a = '0; i_chk_addr_b = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wr_enable", o_wr_enable, 0);
    chk("reset_wr_addr", o_wr_addr, 0);
    chk("reset_wr_data", o_wr_data, 0);
    chk("reset_ld_ready", o_ld_ready, 1);
    chk("reset_waw_err", o_waw_err, 0);
    chk("reset_busy_a", o_busy_a, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // ALU write of x5 and forwarding of it the next cycle.
    cycle(1, 5'd5, 32'h1234, 0, '0, '0, 0, '0, '0, '0, acc);
    idle(5'd5, '0);
    #1;
    chk("t1_fwd_valid_a", o_fwd_valid_a, 1);
    chk("t1_fwd_data_a", o_fwd_data_a, 32'h1234);
    chk("t1_busy_a", o_busy_a, 0);

    // ALU and load collide: load parks, then drains.
    cycle(1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBEEF, 0, '0, '0, '0, acc);
    chk("t2_ld_accepted", acc, 1);
    idle('0, '0);
    #1;
    chk("t2_ld_ready_low", o_ld_ready, 0);
    chk("t2_wr_addr", o_wr_addr, 3);
    idle('0, '0);
    #1;
    chk("t2_wr_addr_ld", o_wr_addr, 7);
    chk("t2_wr_data_ld", o_wr_data, 32'hBEEF);
    chk("t2_ld_ready_back", o_ld_ready, 1);

    // Busy then forward then clear for x9.
    cycle(0, '0, '0, 0, '0, '0, 1, 5'd9, 5'd9, '0, acc);
    idle(5'd9, 5'd9);
    #1;
    chk("t3_busy", o_busy_a, 1);
    cycle(1, 5'd9, 32'h9999, 0, '0, '0, 0, '0, 5'd9, 5'd9, acc);
    idle(5'd9, 5'd9);
    #1;
    chk("t3_fwd", o_fwd_valid_a, 1);
    chk("t3_busy_fwd", o_busy_a, 0);
    idle(5'd9, 5'd9);

    // x0 is never written nor marked busy.
    cycle(1, '0, 32'hFFFF, 0, '0, '0, 1, '0, '0, '0, acc);
    idle('0, '0);
    #1;
    chk("t4_wr_enable_x0", o_wr_enable, 0);
    chk("t4_busy_x0", o_busy_a, 0);

    // Reset while a load is parked; the parked load must never be written.
    cycle(0, '0, '0, 0, '0, '0, 1, 5'd7, '0, '0, acc);
    cycle(1, 5'd3, 32'h3333, 1, 5'd7, 32'hC0DE, 0, '0, 5'd7, '0, acc);
    idle(5'd7, '0);
    #1;
    chk("t5_ld_held", o_ld_ready, 0);
    async_reset(5'd7);
    repeat (4) idle(5'd7, '0);

    // Random traffic with periodic ALU bursts that starve the buffer.
    lp = 0; lrd = '0; ldd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!lp && $urandom_range(0, 9) < 4) begin
        lp  = 1;
        lrd = AW'($urandom_range(1, 7));
        ldd = $urandom;
      end
      av  = (i % 200 < 30) ? 1'b1 : 1'($urandom_range(0, 1));
      ard = AW'($urandom_range(1, 7));
      ad  = $urandom;
      ird = AW'($urandom_range(1, 7));
      iv  = ($urandom_range(0, 3) == 0) && !m_busy[ird];
      ca  = AW'($urandom_range(0, 7));
      cb  = AW'($urandom_range(0, 7));
      cycle(av, ard, ad, lp, lrd, ldd, iv, ird, ca, cb, acc);
      if (acc) lp = 0;
    end
    repeat (4) idle('0, '0);
    chk("scoreboard_drained", exp_q.size(), 0);

    // WAW on x9 sets a sticky error that only reset clears.
    model_clear();
    async_reset('0);
    cycle(0, '0, '0, 0, '0, '0, 1, 5'd9, 5'd9, '0, acc);
    cycle(0, '0, '0, 0, '0, '0, 1, 5'd9, 5'd9, '0, acc);
    for (int k = 0; k < 3; k++) begin
      idle(5'd9, '0);
      #1;
      chk("t6_waw_sticky", o_waw_err, 1);
    end
    cycle(1, 5'd9, 32'h0909, 0, '0, '0, 0, '0, 5'd9, '0, acc);
    idle(5'd9, '0);
    #1;
    chk("t6_waw_after_wb", o_waw_err, 1);
    async_reset(5'd9);
    idle(5'd9, '0);
    #1;
    chk("t6_waw_cleared", o_waw_err, 0);
    idle('0, '0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Pipeline-side controller that drives the write port of the CPU register file and tracks which registers have pending writes.
- Merges two result sources into the single write port:
  - the ALU, which always has priority;
  - the load unit, which uses a valid/ready handshake and a 1-entry holding buffer.
- Holds a scoreboard of busy registers for issue-stage hazard checks.
- Provides forwarding of the in-flight write, because the register file reads combinationally and commits on the clock edge.

Parameters:
- DATA_WIDTH_P, 32, register data width
- ADDR_WIDTH_P, 5, register index width
- DEPTH_P, 32, number of architectural registers (scoreboard size)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- i_issue_valid  input  1  instruction issued that will write i_issue_rd
- i_issue_rd  input  ADDR_WIDTH_P  destination register of the issued instruction
- i_alu_valid  input  1  ALU result valid; always accepted
- i_alu_rd  input  ADDR_WIDTH_P  ALU destination register
- i_alu_data  input  DATA_WIDTH_P  ALU result
- i_ld_valid  input  1  load result valid
- o_ld_ready  output  1  load result accepted this cycle when high together with i_ld_valid
- i_ld_rd  input  ADDR_WIDTH_P  load destination register
- i_ld_data  input  DATA_WIDTH_P  load data
- o_wr_enable  output  1  register file write enable (registered)
- o_wr_addr  output  ADDR_WIDTH_P  register file write address (registered)
- o_wr_data  output  DATA_WIDTH_P  register file write data (registered)
- i_chk_addr_a  input  ADDR_WIDTH_P  source register A queried by issue stage
- i_chk_addr_b  input  ADDR_WIDTH_P  source register B queried by issue stage
- o_busy_a  output  1  source A has an outstanding writer that is not yet forwardable
- o_busy_b  output  1  source B has an outstanding writer that is not yet forwardable
- o_fwd_valid_a  output  1  use o_fwd_data_a instead of register file read data for A
- o_fwd_data_a  output  DATA_WIDTH_P  forwarded value for A
- o_fwd_valid_b  output  1  use o_fwd_data_b instead of register file read data for B
- o_fwd_data_b  output  DATA_WIDTH_P  forwarded value for B
- o_waw_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (reset_n low, asynchronous):
  - o_wr_enable=0, o_wr_addr=0, o_wr_data=0.
  - Holding buffer empty; all scoreboard bits clear; o_waw_err=0.
  - As a consequence, o_ld_ready=1 and all busy/fwd outputs are 0.
  - Reset asserted mid-operation discards the held load and any in-flight write; the register file write is suppressed from that point.
- Register x0:
  - Any result with rd=0 is accepted and dropped; it never asserts o_wr_enable.
  - An issue with rd=0 sets no busy bit.
  - Busy and fwd outputs are always 0 for address 0.
- Write stage W (registered outputs). Selection at each rising edge, in priority order:
  1. i_alu_valid → W gets the ALU result.
  2. Else holding buffer valid → W gets the buffer contents; the buffer empties.
  3. Else i_ld_valid && o_ld_ready → W gets the load result directly.
  4. Else o_wr_enable=0.
- Load capture: if i_ld_valid && o_ld_ready && i_alu_valid, the load result is captured into the holding buffer.
- o_ld_ready = !hold_valid (combinational from state only).
- Latency: a result presented in cycle N appears on o_wr_* in cycle N+1 and is committed to the register file at the end of N+1. A result held in the buffer takes at least one extra cycle.
- Scoreboard, per register r≠0:
  - Set at the edge where i_issue_valid and i_issue_rd=r.
  - Cleared at the edge where a result for r is loaded into W.
  - Set and clear on the same register at the same edge → set wins.
  - Issue to a register that is already busy (WAW) → o_waw_err is set and stays set until reset; the busy bit remains 1.
- Hazard and forwarding (combinational), shown for port A; B is identical:
  - o_fwd_valid_a = o_wr_enable && o_wr_addr==i_chk_addr_a && addr≠0.
  - o_fwd_data_a = o_wr_data.
  - o_busy_a = busy[i_chk_addr_a] && !o_fwd_valid_a.
- Ordering guarantee: no two outstanding writers share an rd, because the issue stage stalls on busy. The ALU/load reordering through the holding buffer is therefore legal.
- Back-to-back ALU results starve the holding buffer. The buffer drains in the first cycle with i_alu_valid=0, and o_ld_ready stays 0 until then.

Test Plan:
- Reset, then ALU result rd=5, data 0x1234 at cycle 1 → o_wr_enable=1, o_wr_addr=5, o_wr_data=0x1234 in cycle 2; with i_chk_addr_a=5 in cycle 2 → o_fwd_valid_a=1, o_fwd_data_a=0x1234, o_busy_a=0.
- ALU rd=3 and load rd=7 (0xBEEF) in the same cycle → ALU write on the next cycle; o_ld_ready=0 during that cycle; load write of rd=7 0xBEEF one cycle later; o_ld_ready returns to 1.
- Issue rd=9, then query rd=9 → o_busy=1 until the result is in W, then fwd_valid=1; the following cycle both are 0.
- Issue rd=9 twice with no result in between → o_waw_err=1 and it stays 1 until reset_n falls.
- ALU result rd=0 (0xFFFF) → o_wr_enable stays 0; issue rd=0 → o_busy for address 0 stays 0.
- Load held in the buffer while reset_n is pulsed low asynchronously mid-cycle → o_wr_enable=0 immediately, o_ld_ready=1, scoreboard clear, and no write of the held data after release.
